// File: rtl/instr_fetch_unit_if.sv
// Signal bundle between the fetch unit, instruction memory, execute
// (redirects) and the control decoder.
interface instr_fetch_unit_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc,
    output instr_valid, instr, instr_pc, opcode, funct3, funct7,
    input  instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc,
    input  instr_valid, instr, instr_pc, opcode, funct3, funct7,
    output instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: sequential PC requests, in-order buffer of
// returned words, redirect flush with discard of in-flight responses.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  fetch
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW:0]  DEPTH_C  = (CW + 1)'(FIFO_DEPTH);
  localparam logic [31:0]  NOP      = 32'h0000_0013;
  localparam logic [31:0]  START_PC = RESET_PC & 32'hFFFF_FFFC;

  logic [31:0]   pc_reg;
  logic [31:0]   resp_pc_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] outstanding_reg;
  logic [CW-1:0] drop_cnt_reg;
  logic [31:0]   data_mem [FIFO_DEPTH];
  logic [31:0]   pc_mem   [FIFO_DEPTH];

  logic [CW:0]   credit_used;
  logic          req_valid;
  logic          req_fire;
  logic          resp_drop;
  logic          push;
  logic          pop;
  logic          head_valid;
  logic [31:0]   head_instr;
  logic [31:0]   head_pc;
  logic [31:0]   redirect_aligned;

  // Buffered words plus requests still in flight may never exceed the
  // buffer size, so every returning response is guaranteed a slot.
  assign credit_used      = {1'b0, count_reg} + {1'b0, outstanding_reg};
  assign req_valid        = rst_n & ~fetch.redirect_valid & (credit_used < DEPTH_C);
  assign req_fire         = req_valid & fetch.imem_req_ready;
  assign redirect_aligned = fetch.redirect_pc & 32'hFFFF_FFFC;

  assign resp_drop  = fetch.imem_resp_valid & (drop_cnt_reg != '0);
  assign push       = fetch.imem_resp_valid & ~fetch.redirect_valid & (drop_cnt_reg == '0);
  assign head_valid = (count_reg != '0);
  assign pop        = head_valid & fetch.instr_ready & ~fetch.redirect_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg          <= START_PC;
      resp_pc_reg     <= START_PC;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
    end else if (fetch.redirect_valid) begin
      pc_reg          <= redirect_aligned;
      resp_pc_reg     <= redirect_aligned;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      // Everything still in flight belongs to the old path; a response
      // arriving right now is discarded as well.
      outstanding_reg <= outstanding_reg - CW'(fetch.imem_resp_valid);
      drop_cnt_reg    <= outstanding_reg - CW'(fetch.imem_resp_valid);
    end else begin
      if (req_fire) begin
        pc_reg <= pc_reg + 32'd4;
      end
      outstanding_reg <= outstanding_reg + CW'(req_fire) - CW'(fetch.imem_resp_valid);
      if (resp_drop) begin
        drop_cnt_reg <= drop_cnt_reg - CW'(1);
      end
      if (push) begin
        wr_ptr_reg  <= wr_ptr_reg + AW'(1);
        resp_pc_reg <= resp_pc_reg + 32'd4;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      data_mem[wr_ptr_reg] <= fetch.imem_resp_data;
      pc_mem[wr_ptr_reg]   <= resp_pc_reg;
    end
  end

  assign head_instr = head_valid ? data_mem[rd_ptr_reg] : NOP;
  assign head_pc    = head_valid ? pc_mem[rd_ptr_reg] : 32'd0;

  assign fetch.imem_req_valid = req_valid;
  assign fetch.imem_req_addr  = pc_reg;
  assign fetch.instr_valid    = head_valid;
  assign fetch.instr          = head_instr;
  assign fetch.instr_pc       = head_pc;
  assign fetch.opcode         = head_instr[6:0];
  assign fetch.funct3         = head_instr[14:12];
  assign fetch.funct7         = head_instr[31:25];

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front end of the core: issues sequential PC-based requests to instruction memory and buffers returned words in a small in-order FIFO.
- Presents the head instruction, its PC and its pre-sliced opcode/funct3/funct7 fields to the control decoder, with a valid/ready stall handshake.
- Accepts branch/jump redirects from execute: flushes the FIFO and discards in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, address of first fetch after reset
FIFO_DEPTH, 4, instruction buffer entries; power of two, ≥2; also the cap on (buffered + outstanding) requests

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_addr  out  32  fetch word address (bits[1:0]=00)
imem_req_ready  in  1  memory accepts request this cycle
imem_resp_valid  in  1  response word valid; responses return in request order, ≥1 cycle after handshake
imem_resp_data  in  32  instruction word
redirect_valid  in  1  branch taken / jump; flush and refetch
redirect_pc  in  32  new fetch address
instr_valid  out  1  FIFO head valid
instr_ready  in  1  decode consumes head this cycle
instr  out  32  head instruction; 32'h0000_0013 (NOP) when instr_valid=0
instr_pc  out  32  PC of head; 0 when instr_valid=0
opcode  out  7  instr[6:0]
funct3  out  3  instr[14:12]
funct7  out  7  instr[31:25]

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - pc←RESET_PC; FIFO empty; outstanding=0; drop_cnt=0.
  - Outputs: imem_req_valid=0, instr_valid=0, instr=NOP, instr_pc=0.
  - Reset mid-operation: memory responses arriving during or after reset for pre-reset requests must not occur; the memory is reset alongside this block.
- State: pc, FIFO (data+pc per entry), outstanding and drop_cnt counters, each $clog2(FIFO_DEPTH+1) bits.
- Request issue:
  - imem_req_valid = rst_n & !redirect_valid & (count + outstanding < FIFO_DEPTH).
  - imem_req_addr = pc.
  - On handshake: pc←pc+4 (wraps modulo 2^32 from 32'hFFFF_FFFC to 0); outstanding+1.
  - Once asserted, imem_req_valid/addr stay stable until ready, except when dropped by redirect.
- Response:
  - Each imem_resp_valid decrements outstanding.
  - If drop_cnt>0: word discarded, drop_cnt−1.
  - Otherwise the word is pushed with its PC; push PC comes from an internal resp_pc register that advances by 4 per accepted response.
  - The credit rule guarantees no overflow, so a push is never refused.
- Output handshake:
  - Pop when instr_valid & instr_ready.
  - Push and pop in the same cycle allowed; count unchanged.
  - Fields are combinational slices of the registered FIFO head.
- Redirect (redirect_valid=1 in cycle T):
  - FIFO flushed; any pop that cycle is ignored.
  - drop_cnt ← outstanding − (imem_resp_valid at T ? 1 : 0); a response at T is itself discarded.
  - A request handshake cannot occur at T (req_valid forced 0).
  - pc and resp_pc ← {redirect_pc[31:2],2'b00}; misaligned low bits are silently cleared.
  - First request for the new PC is presented at T+1.
  - Redirect has priority over every other event that cycle.
  - Back-to-back redirects: last one wins; drop_cnt is recomputed each time.
- Latency: with memory ready and 1-cycle response latency, request at T gives instr_valid at T+2.
- Full: while count+outstanding=FIFO_DEPTH, imem_req_valid=0 until a pop.

Test Plan:
1. Reset, instr_ready=1, memory 1-cycle latency returning mem[a]=a → requests 0,4,8,… on consecutive cycles; instr_valid from cycle 2; instr_pc 0,4,8 with instr=instr_pc; opcode=instr[6:0].
2. instr_ready=0 for 10 cycles, DEPTH=4 → exactly 4 requests issued, then imem_req_valid=0; after instr_ready=1 the words pop in order 0,4,8,12 and fetch resumes at 16.
3. Memory latency 3 cycles with 3 outstanding; redirect_pc=32'h100 → 3 stale responses dropped, FIFO empty; next instr_pc=32'h100, then 32'h104.
4. Redirect in the same cycle as a response and a pop → response discarded, no pop counted; imem_req_addr=redirect target next cycle; redirect_pc=32'h203 fetches from 32'h200.
5. imem_req_ready held 0 for 5 cycles → imem_req_valid/addr stable throughout; instr=32'h0000_0013, instr_valid=0 once the FIFO drains.
6. Assert rst_n=0 mid-stream with 2 entries buffered → next cycle instr_valid=0, imem_req_valid=0; after release the first request is RESET_PC.
